issue_queue: RTL and testbench

- In-order issue queue; consumes ISSUE_QUEUE_ELEMENT records produced by the decode stage and releases them to the execute stage.
- Buffers up to DEPTH decoded instructions.
- Blocks the head entry until its source registers have no pending writer (busy-bit scoreboard).
- Fills register operands from the register file at issue time.

---
 rtl/issue_queue_pkg.sv | 22 ++
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/issue_queue.sv | 130 +++++++++++++
 tb/tb_issue_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: the decoded-instruction record exchanged with
// the decode stage, default queue depth and register address width.
package issue_queue_pkg;

    localparam int IQ_DEPTH   = 4;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [5:0]            opcode;
        logic                  num1_need;
        logic [REG_ADDR_W-1:0] num1_addr;
        logic [31:0]           num1;
        logic                  num2_need;
        logic [REG_ADDR_W-1:0] num2_addr;
        logic [31:0]           num2;
        logic                  write_reg_need;
        logic [REG_ADDR_W-1:0] write_reg_addr;
    } ISSUE_QUEUE_ELEMENT;

    localparam int IQ_ELEM_W = $bits(ISSUE_QUEUE_ELEMENT);

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue of a writer,
// cleared on writeback (set wins on collision), register 0 never busy.
module reg_scoreboard
    import issue_queue_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic                  rd_busy1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  rd_busy2
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next    = busy;
        busy_next[0] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (set_en && set_addr == REG_ADDR_W'(i)) begin
                busy_next[i] = 1'b1;
            end else if (clr_en && clr_addr == REG_ADDR_W'(i)) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rd_busy1 = 1'b0;
        rd_busy2 = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr1 == REG_ADDR_W'(i)) rd_busy1 = busy[i];
            if (rd_addr2 == REG_ADDR_W'(i)) rd_busy2 = busy[i];
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue with busy-bit scoreboard and issue-time operand fill.
// Define ISSUE_BYPASS_EN to let an element issue straight from in_elem when the queue is empty.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH    = IQ_DEPTH,
    parameter int NUM_REGS = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IQ_ELEM_W-1:0]           in_elem,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IQ_ELEM_W-1:0]           out_elem,
    output logic [REG_ADDR_W-1:0]          rf_raddr1,
    input  logic [31:0]                    rf_rdata1,
    output logic [REG_ADDR_W-1:0]          rf_raddr2,
    input  logic [31:0]                    rf_rdata2,
    input  logic                           wb_valid,
    input  logic [REG_ADDR_W-1:0]          wb_addr,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    function automatic logic src_ok(input logic need, input logic [REG_ADDR_W-1:0] addr,
                                    input logic busy_bit);
        return !need || addr == '0 || !busy_bit;
    endfunction

    ISSUE_QUEUE_ELEMENT mem [DEPTH];
    ISSUE_QUEUE_ELEMENT in_e;
    ISSUE_QUEUE_ELEMENT head;
    ISSUE_QUEUE_ELEMENT cand;
    ISSUE_QUEUE_ELEMENT out_e;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             busy1;
    logic             busy2;
    logic             cand_ok;
    logic             bypass;
    logic             push;
    logic             issue;
    logic             pop;

    assign in_e  = ISSUE_QUEUE_ELEMENT'(in_elem);
    assign head  = mem[rd_ptr];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // The element under consideration for issue is the head, or in_elem when bypassing an empty queue.
`ifdef ISSUE_BYPASS_EN
    assign cand   = empty ? in_e : head;
    assign cand_ok = src_ok(cand.num1_need, cand.num1_addr, busy1) &&
                     src_ok(cand.num2_need, cand.num2_addr, busy2);
    assign bypass = rst_n && empty && in_valid && !flush && cand_ok && out_ready;
    assign out_valid = rst_n && !flush && cand_ok && (!empty || bypass);
`else
    assign cand   = head;
    assign cand_ok = src_ok(cand.num1_need, cand.num1_addr, busy1) &&
                     src_ok(cand.num2_need, cand.num2_addr, busy2);
    assign bypass = 1'b0;
    assign out_valid = rst_n && !flush && !empty && cand_ok;
`endif

    assign in_ready = rst_n && !full && !flush;
    assign issue    = out_valid && out_ready;
    assign push     = in_valid && in_ready && !bypass;
    assign pop      = issue && !bypass;

    assign rf_raddr1 = cand.num1_addr;
    assign rf_raddr2 = cand.num2_addr;

    always_comb begin
        out_e = cand;
        if (cand.num1_need) out_e.num1 = rf_rdata1;
        if (cand.num2_need) out_e.num2 = rf_rdata2;
    end

    assign out_elem = IQ_ELEM_W'(out_e);
    assign count    = count_q;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && cand.write_reg_need),
        .set_addr (cand.write_reg_addr),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .rd_addr1 (cand.num1_addr),
        .rd_busy1 (busy1),
        .rd_addr2 (cand.num2_addr),
        .rd_busy2 (busy2)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_e;
    end

    // Flush realigns the read pointer onto the write pointer rather than resetting both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios then random traffic, checked every cycle
// against a queue-and-busy-array reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    ISSUE_QUEUE_ELEMENT in_e;
    logic               out_valid;
    logic               out_ready;
    ISSUE_QUEUE_ELEMENT out_e;
    logic [4:0]         rf_raddr1;
    logic [31:0]        rf_rdata1;
    logic [4:0]         rf_raddr2;
    logic [31:0]        rf_rdata2;
    logic               wb_valid;
    logic [4:0]         wb_addr;
    logic               flush;
    logic [2:0]         count;

    int checks = 0;
    int errors = 0;

    ISSUE_QUEUE_ELEMENT q[$];
    bit                 busy [32];

    issue_queue #(.DEPTH(DEPTH), .NUM_REGS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_elem   (in_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_elem  (out_e),
        .rf_raddr1 (rf_raddr1),
        .rf_rdata1 (rf_rdata1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .flush     (flush),
        .count     (count)
    );

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : {16'hC0DE, 11'h0, a};
    endfunction

    assign rf_rdata1 = rf_val(rf_raddr1);
    assign rf_rdata2 = rf_val(rf_raddr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ISSUE_QUEUE_ELEMENT mk(input logic [5:0] op,
            input logic n1, input logic [4:0] a1, input logic [31:0] v1,
            input logic n2, input logic [4:0] a2, input logic [31:0] v2,
            input logic w, input logic [4:0] wa);
        ISSUE_QUEUE_ELEMENT e;
        e.opcode = op; e.num1_need = n1; e.num1_addr = a1; e.num1 = v1;
        e.num2_need = n2; e.num2_addr = a2; e.num2 = v2;
        e.write_reg_need = w; e.write_reg_addr = wa;
        return e;
    endfunction

    function automatic bit srcs_ok(input ISSUE_QUEUE_ELEMENT e);
        bit ok1, ok2;
        ok1 = !e.num1_need || e.num1_addr == 0 || !busy[e.num1_addr];
        ok2 = !e.num2_need || e.num2_addr == 0 || !busy[e.num2_addr];
        return ok1 && ok2;
    endfunction

    function automatic ISSUE_QUEUE_ELEMENT fill(input ISSUE_QUEUE_ELEMENT e);
        ISSUE_QUEUE_ELEMENT f;
        f = e;
        if (e.num1_need) f.num1 = rf_val(e.num1_addr);
        if (e.num2_need) f.num2 = rf_val(e.num2_addr);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ISSUE_QUEUE_ELEMENT indep(input int i);
        return mk(6'h0D, 1'b0, 5'd0, 32'(i), 1'b0, 5'd0, 32'(i + 100), 1'b0, 5'd0);
    endfunction

    task automatic model_reset();
        q.delete();
        foreach (busy[i]) busy[i] = 1'b0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        ISSUE_QUEUE_ELEMENT exp_e;
        bit ev, er, byp;
        @(negedge clk);
        er = (q.size() < DEPTH) && !flush;
        ev = 1'b0;
        byp = 1'b0;
        exp_e = '0;
        if (!flush && q.size() > 0 && srcs_ok(q[0])) begin
            ev = 1'b1;
            exp_e = fill(q[0]);
        end
`ifdef ISSUE_BYPASS_EN
        else if (!flush && q.size() == 0 && in_valid && out_ready && srcs_ok(in_e)) begin
            ev = 1'b1;
            byp = 1'b1;
            exp_e = fill(in_e);
        end
`endif
        chk("in_ready", 128'(in_ready), 128'(er));
        chk("out_valid", 128'(out_valid), 128'(ev));
        chk("count", 128'(count), 128'(q.size()));
        if (ev) chk("out_elem", 128'(out_e), 128'(exp_e));
        if (wb_valid && wb_addr != 0) busy[wb_addr] = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (ev && out_ready) begin
                if (exp_e.write_reg_need && exp_e.write_reg_addr != 0) busy[exp_e.write_reg_addr] = 1'b1;
                if (!byp) void'(q.pop_front());
            end
            if (in_valid && er && !byp) q.push_back(in_e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_e = '0;
        idle();
        model_reset();
        #3;
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_count", 128'(count), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ORI r1=r0|5 then dependent ADDIU r2=r1+1
        in_valid = 1'b1;
        in_e = mk(6'h0D, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd5, 1'b1, 5'd1);
        cycle();
        in_e = mk(6'h09, 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd1, 1'b1, 5'd2);
        cycle();
        in_valid = 1'b0;
        #3 chk("dep_stall", 128'(out_valid), 128'(1'b0));
        cycle();
        wb_valid = 1'b1; wb_addr = 5'd1;
        #3 chk("dep_stall_wb", 128'(out_valid), 128'(1'b0));
        cycle();
        wb_valid = 1'b0;
        #3;
        chk("dep_issue", 128'(out_valid), 128'(1'b1));
        chk("dep_num1", 128'(out_e.num1), 128'(32'hC0DE0001));
        chk("dep_num2", 128'(out_e.num2), 128'(32'd1));
        cycle();
        wb_valid = 1'b1; wb_addr = 5'd2;
        cycle();
        idle();

        // Fill to full with out_ready low, fifth push held until a pop frees a slot
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_e = indep(i);
            cycle();
        end
        in_e = indep(4);
        #3;
        chk("full_in_ready", 128'(in_ready), 128'(1'b0));
        chk("full_count", 128'(count), 128'(4));
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        #3 chk("slot_free", 128'(in_ready), 128'(1'b1));
        cycle();
        in_valid = 1'b0;
        #3 chk("refull_count", 128'(count), 128'(4));
        out_ready = 1'b1;
        repeat (5) cycle();

        // Flush with 3 queued; busy bit of an earlier issue survives
        in_valid = 1'b1;
        in_e = mk(6'h0D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd7, 1'b1, 5'd5);
        cycle();
        in_e = indep(10);
        cycle();
        out_ready = 1'b0;
        in_e = indep(11); cycle();
        in_e = indep(12); cycle();
        in_valid = 1'b0; flush = 1'b1;
        #3;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_in_ready", 128'(in_ready), 128'(1'b0));
        cycle();
        flush = 1'b0; out_ready = 1'b1;
        #3 chk("flush_count", 128'(count), 128'(0));
        in_valid = 1'b1;
        in_e = mk(6'h09, 1'b1, 5'd5, 32'd0, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0);
        cycle();
        in_valid = 1'b0;
        #3 chk("flush_busy_kept", 128'(out_valid), 128'(1'b0));
        cycle();
        wb_valid = 1'b1; wb_addr = 5'd5;
        cycle();
        idle();
        cycle();

        // Writing r0 never marks it busy
        in_valid = 1'b1;
        in_e = mk(6'h0D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd9, 1'b1, 5'd0);
        cycle();
        in_e = mk(6'h09, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle();
        in_valid = 1'b0;
        #3 chk("r0_never_busy", 128'(out_valid), 128'(1'b1));
        cycle();

        // Issue writing r3 coincides with writeback of r3: set wins
        in_valid = 1'b1;
        in_e = mk(6'h0D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd2, 1'b1, 5'd3);
        cycle();
        in_e = mk(6'h09, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd0, 1'b0, 5'd0);
        wb_valid = 1'b1; wb_addr = 5'd3;
        cycle();
        in_valid = 1'b0; wb_valid = 1'b0;
        #3 chk("set_wins", 128'(out_valid), 128'(1'b0));
        cycle();
        wb_valid = 1'b1; wb_addr = 5'd3;
        cycle();
        idle();
        cycle();

        // Reset with 2 queued and r4 busy
        in_valid = 1'b1;
        in_e = mk(6'h0D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd1, 1'b1, 5'd4);
        cycle();
        in_e = indep(20);
        cycle();
        out_ready = 1'b0;
        in_e = indep(21);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1;
        in_e = mk(6'h09, 1'b1, 5'd4, 32'd0, 1'b0, 5'd0, 32'd6, 1'b0, 5'd0);
        #3 chk("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
        cycle();
        in_valid = 1'b0;
        #3 chk("post_rst_busy_clear", 128'(out_valid), 128'(1'b1));
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_e = mk(6'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom), 5'($urandom_range(0, 7)));
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_addr   = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
